// File: rtl/serial_adder_ctrl_pkg.sv
// serial_adder_ctrl_pkg: shared FSM encoding and default width for the bit-serial adder
package serial_adder_ctrl_pkg;
  localparam int DEFAULT_WIDTH = 8;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/serial_adder_ctrl_if.sv
// serial_adder_ctrl_if: operand request and result channels of the bit-serial adder
interface serial_adder_ctrl_if
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carryin;
  logic             result_valid;
  logic             result_ready;
  logic [WIDTH-1:0] sum;
  logic             carryout;
  logic             busy;
  modport master (
    output start_valid, a, b, carryin, result_ready,
    input  start_ready, result_valid, sum, carryout, busy
  );
  modport slave (
    input  start_valid, a, b, carryin, result_ready,
    output start_ready, result_valid, sum, carryout, busy
  );
endinterface

// File: rtl/serial_adder_ctrl_full_adder.sv
// structuralFullAdder: gate-level one-bit full adder cell
module structuralFullAdder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);
  logic p, g, t;
  xor x_p (p, a, b);
  xor x_s (s, p, cin);
  and a_g (g, a, b);
  and a_t (t, p, cin);
  or  o_c (co, g, t);
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: sequences one full adder cell over WIDTH cycles, LSB first
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  serial_adder_ctrl_if.slave    bus
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             carry_q, carry_d, co_q, co_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             cell_s, cell_co;
  structuralFullAdder u_cell (
    .a   (a_q[0]),
    .b   (b_q[0]),
    .cin (carry_q),
    .s   (cell_s),
    .co  (cell_co)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      co_q    <= co_d;
      idx_q   <= idx_d;
    end
  end
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    co_d    = co_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: if (bus.start_valid) begin
        a_d     = bus.a;
        b_d     = bus.b;
        carry_d = bus.carryin;
        sum_d   = '0;
        idx_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        sum_d   = {cell_s, sum_q[WIDTH-1:1]};
        carry_d = cell_co;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        // counter parks on the last bit rather than wrapping
        if (idx_q == IW'(WIDTH - 1)) begin
          co_d    = cell_co;
          state_d = DONE;
        end else idx_d = idx_q + IW'(1);
      end
      DONE: state_d = bus.result_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  assign bus.start_ready  = state_q == IDLE;
  assign bus.result_valid = state_q == DONE;
  assign bus.busy         = state_q != IDLE;
  assign bus.sum          = sum_q;
  assign bus.carryout     = co_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: randomized scoreboard bench for the bit-serial adder controller
module tb_serial_adder_ctrl;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  serial_adder_ctrl_if #(.WIDTH(W)) bus ();
  serial_adder_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [W:0] res;
    int         acc;
  } exp_t;
  exp_t sb[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int bp = 0;
  always @(posedge clk) cyc++;
  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask
  task automatic fail_now(string name);
    tests++;
    fails++;
    $display("FAIL %s: bound expired or unexpected event at cycle %0d", name, cyc);
  endtask
  // consumer: pops the scoreboard on each new result and applies backpressure
  initial begin
    exp_t cur;
    int   held;
    logic pv;
    pv = 1'b0;
    held = 0;
    cur.res = '0;
    cur.acc = 0;
    forever begin
      @(negedge clk);
      if (bus.result_valid) begin
        if (!pv) begin
          held = 0;
          if (sb.size() == 0) fail_now("unexpected_result");
          else begin
            cur = sb.pop_front();
            check("latency", 64'(cyc - cur.acc), 64'(W));
            check("sum", 64'(bus.sum), 64'(cur.res[W-1:0]));
            check("carryout", 64'(bus.carryout), 64'(cur.res[W]));
          end
        end else begin
          check("hold_result", 64'({bus.carryout, bus.sum}), 64'(cur.res));
          check("hold_start_ready", 64'(bus.start_ready), 64'(0));
          check("hold_busy", 64'(bus.busy), 64'(1));
        end
        held++;
        bus.result_ready = held > bp;
      end else bus.result_ready = 1'($urandom);
      pv = bus.result_valid;
    end
  end
  task automatic do_op(logic [W-1:0] a, logic [W-1:0] b, logic ci);
    int n;
    n = 0;
    @(negedge clk);
    bus.start_valid = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.carryin = ci;
    while (!bus.start_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.start_ready) fail_now("accept_timeout");
    else sb.push_back('{res: {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci}, acc: cyc + 1});
    @(negedge clk);
    bus.start_valid = 1'b0;
    bus.a = W'($urandom);
    bus.b = W'($urandom);
    bus.carryin = 1'($urandom);
  endtask
  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || !bus.start_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) fail_now("idle_timeout");
  endtask
  initial begin
    bus.start_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.carryin = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_start_ready", 64'(bus.start_ready), 64'(1));
    check("rst_result_valid", 64'(bus.result_valid), 64'(0));
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_sum", 64'(bus.sum), 64'(0));
    check("rst_carryout", 64'(bus.carryout), 64'(0));
    rst_n = 1'b1;
    bp = 0;
    do_op(8'h00, 8'h00, 1'b0);
    wait_idle();
    do_op(8'hFF, 8'h01, 1'b0);
    wait_idle();
    do_op(8'hA5, 8'h5A, 1'b1);
    do_op(8'h3C, 8'h0F, 1'b0);
    wait_idle();
    bp = 5;
    do_op(8'h81, 8'h7F, 1'b1);
    do_op(8'h10, 8'h20, 1'b0);
    wait_idle();
    bp = 0;
    do_op(8'h12, 8'h34, 1'b0);
    bus.start_valid = 1'b1;
    bus.a = 8'hFF;
    bus.b = 8'hFF;
    bus.carryin = 1'b1;
    @(negedge clk);
    check("run_start_ready", 64'(bus.start_ready), 64'(0));
    check("run_busy", 64'(bus.busy), 64'(1));
    bus.start_valid = 1'b0;
    wait_idle();
    do_op(8'hC3, 8'h3C, 1'b1);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_start_ready", 64'(bus.start_ready), 64'(1));
    check("abort_result_valid", 64'(bus.result_valid), 64'(0));
    check("abort_sum", 64'(bus.sum), 64'(0));
    check("abort_busy", 64'(bus.busy), 64'(0));
    sb.delete();
    rst_n = 1'b1;
    do_op(8'h77, 8'h99, 1'b1);
    wait_idle();
    for (int i = 0; i < 40; i++) begin
      bp = $urandom_range(0, 3);
      do_op(W'($urandom), W'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 1) wait_idle();
    end
    wait_idle();
    check("sb_drained", 64'(sb.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
